// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the fifo_stream_reader slice: data width and controller state encoding.
package fifo_stream_reader_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] RUN_ENC   = 2'd1;
  localparam logic [1:0] FLUSH_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_RUN   = RUN_ENC,
    ST_FLUSH = FLUSH_ENC
  } state_t;

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Circular output buffer: push at tail, pop at head, clear empties it in one edge.
module stream_skid_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (occ != OCC_W'(DEPTH));
  assign do_pop  = pop && (occ != '0);

  // Head reads zero while empty so stale words never appear on the output.
  assign head = (occ != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for fifo_sync: issues safe pops, absorbs read latency and
// re-presents words as a valid/ready stream with enable gating and flush.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count,
  output state_t            state_dbg
);

  // Stream handshake: a word transfers on any edge where m_valid & m_ready;
  // m_valid never depends on m_ready and m_data is held while m_valid & ~m_ready.

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

  state_t             state;
  state_t             state_next;
  logic [RD_LAT-1:0]  inflight_sr;
  logic [SUM_W-1:0]   inflight_cnt;
  logic [SUM_W-1:0]   pending;
  logic [OCC_W-1:0]   occ;
  logic               flush_start;
  logic               buf_push;
  logic               buf_pop;

  assign state_dbg = state;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + SUM_W'(inflight_sr[i]);
    end
  end

  // Registered occupancy plus outstanding reads bounds issue, keeping m_ready off this path.
  assign pending = SUM_W'(occ) + inflight_cnt;

  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush)   state_next = ST_FLUSH;
        else if (en) state_next = ST_RUN;
      end
      ST_RUN: begin
        fifo_read = en && !flush && !fifo_empty && (pending < SUM_W'(BUF_DEPTH));
        if (flush) begin
          state_next = ST_FLUSH;
        end else if (!en && (occ == '0) && (inflight_cnt == '0)) begin
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        fifo_read = !fifo_empty;
        if (fifo_empty && (inflight_cnt == '0)) begin
          state_next = en ? ST_RUN : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Bit k set means a read issued k+1 cycles ago; the top tap marks fifo_data valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_sr <= '0;
    end else begin
      inflight_sr[0] <= fifo_read;
      for (int i = 1; i < RD_LAT; i++) begin
        inflight_sr[i] <= inflight_sr[i-1];
      end
    end
  end

  assign flush_start = flush && (state != ST_FLUSH);
  assign buf_push    = inflight_sr[RD_LAT-1] && (state == ST_RUN) && !flush;
  assign buf_pop     = m_valid && m_ready;

  stream_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_start),
    .push      (buf_push),
    .push_data (fifo_data),
    .pop       (buf_pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != '0);
  assign busy    = (state == ST_FLUSH) ||
                   ((state == ST_RUN) && ((occ != '0) || (inflight_cnt != '0)));

  always_ff @(posedge clk) begin
    if (rst)          word_count <= '0;
    else if (buf_pop) word_count <= word_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader against a behavioural 16-deep, 1-cycle-latency FIFO.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_wr = 1'b0;
  logic [15:0] fifo_wdata = '0;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_read;
  logic        m_valid;
  logic [15:0] m_data;
  logic        busy;
  logic [15:0] word_count;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int acc_count = 0;
  int cyc = 0;
  int rd_cyc_q[$];
  int acc_cyc_q[$];
  logic [15:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural fifo_sync, RD_LAT = 1
  logic [15:0] fmem [16];
  logic [3:0]  fwp, frp;
  logic [4:0]  fcount;
  assign fifo_empty = (fcount == 5'd0);

  always @(posedge clk) begin
    if (fifo_rst) begin
      fwp <= '0; frp <= '0; fcount <= '0; fifo_data <= '0;
    end else begin
      if (fifo_wr) begin
        fmem[fwp] <= fifo_wdata;
        fwp <= fwp + 4'd1;
      end
      if (fifo_read && fcount != 5'd0) begin
        fifo_data <= fmem[frp];
        frp <= frp + 4'd1;
      end
      fcount <= fcount + {4'd0, fifo_wr} - {4'd0, (fifo_read && fcount != 5'd0)};
    end
  end

  fifo_stream_reader #(
    .DATA_W(16), .RD_LAT(1), .BUF_DEPTH(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .word_count(word_count), .state_dbg(state_dbg)
  );

  // scoreboard monitor
  always @(negedge clk) begin
    if (fifo_read === 1'b1) begin
      rd_count++;
      rd_cyc_q.push_back(cyc);
      checks++;
      if (fifo_empty !== 1'b0) begin
        errors++;
        $display("FAIL read_while_empty: fifo_read=1 with fifo_empty=%b at cycle %0d", fifo_empty, cyc);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      acc_count++;
      acc_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h with nothing expected", m_data);
      end else begin
        logic [15:0] exp_w;
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          errors++;
          $display("FAIL stream_data: got %h expected %h", m_data, exp_w);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fifo_push(input logic [15:0] w);
    fifo_wr = 1'b1;
    fifo_wdata = w;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && fifo_empty === 1'b1) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: exp_q=%0d busy=%b empty=%b after %0d cycles", name, exp_q.size(), busy, fifo_empty, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks += 6;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    step();
    rst = 1'b0; fifo_rst = 1'b0;
    step();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 6; i++) begin
      fifo_push(16'h10 + 16'(i));
      exp_q.push_back(16'h10 + 16'(i));
    end
    rd_count = 0;
    rd_cyc_q.delete();
    acc_cyc_q.delete();
    m_ready = 1'b1;
    en = 1'b1;
    wait_idle("drain", 100);
    @(negedge clk);
    checks += 4;
    if (rd_count != 6) begin errors++; $display("FAIL drain_reads: got %0d expected 6", rd_count); end
    if (word_count !== 16'd6) begin errors++; $display("FAIL drain_word_count: got %0d expected 6", word_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b expected 0", busy); end
    if (acc_cyc_q.size() != 6 || rd_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL drain_accepts: got %0d expected 6", acc_cyc_q.size());
    end else begin
      checks++;
      if (acc_cyc_q[0] - rd_cyc_q[0] != 2) begin
        errors++;
        $display("FAIL drain_latency: got %0d expected 2", acc_cyc_q[0] - rd_cyc_q[0]);
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (acc_cyc_q[i] - acc_cyc_q[i-1] != 1) begin
          errors++;
          $display("FAIL drain_back_to_back: gap %0d at word %0d expected 1", acc_cyc_q[i] - acc_cyc_q[i-1], i);
        end
      end
    end
    step();
    en = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_pressure();
    logic [15:0] wc0;
    wc0 = word_count;
    for (int i = 0; i < 6; i++) begin
      fifo_push(16'h10 + 16'(i));
      exp_q.push_back(16'h10 + 16'(i));
    end
    rd_count = 0;
    m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 16'h10) begin errors++; $display("FAIL bp_hold: got %h expected 0010", m_data); end
      end
    end
    checks += 2;
    if (rd_count != 3) begin errors++; $display("FAIL bp_reads: got %0d expected 3", rd_count); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
    step();
    m_ready = 1'b1;
    wait_idle("bp", 100);
    @(negedge clk);
    checks += 2;
    if (rd_count != 6) begin errors++; $display("FAIL bp_total_reads: got %0d expected 6", rd_count); end
    if (word_count !== wc0 + 16'd6) begin errors++; $display("FAIL bp_word_count: got %0d expected %0d", word_count, wc0 + 16'd6); end
    step();
    en = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_flush();
    logic [15:0] wc0;
    int base_acc, base_rd, n;
    wc0 = word_count;
    for (int i = 0; i < 8; i++) fifo_push(16'h30 + 16'(i));
    exp_q.push_back(16'h30);
    exp_q.push_back(16'h31);
    base_acc = acc_count;
    base_rd = rd_count;
    m_ready = 1'b1;
    en = 1'b1;
    n = 0;
    while (acc_count - base_acc < 2 && n < 50) begin
      step();
      n++;
    end
    m_ready = 1'b0;
    flush = 1'b1;
    checks++;
    if (acc_count - base_acc != 2) begin errors++; $display("FAIL flush_pre_accepts: got %0d expected 2", acc_count - base_acc); end
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_drop: got %b expected 0", m_valid); end
    wait_idle("flush", 100);
    @(negedge clk);
    checks += 4;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_fifo_empty: got %b expected 1", fifo_empty); end
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    if (word_count !== wc0 + 16'd2) begin errors++; $display("FAIL flush_word_count: got %0d expected %0d", word_count, wc0 + 16'd2); end
    if (rd_count - base_rd != 8) begin errors++; $display("FAIL flush_reads: got %0d expected 8", rd_count - base_rd); end
    step();
    m_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_residue: m_valid got %b expected 0", m_valid); end
    step();
  endtask

  task automatic test_gap_enable();
    int base_rd, n;
    en = 1'b1;
    m_ready = 1'b1;
    fifo_push(16'h20);
    exp_q.push_back(16'h20);
    wait_idle("gap_first", 20);
    base_rd = rd_count;
    repeat (5) step();
    @(negedge clk);
    checks += 2;
    if (rd_count != base_rd) begin errors++; $display("FAIL gap_no_reads: got %0d reads expected 0", rd_count - base_rd); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL gap_valid: got %b expected 0", m_valid); end
    step();
    fifo_push(16'h21);
    exp_q.push_back(16'h21);
    wait_idle("gap_second", 20);
    checks++;
    if (rd_count != base_rd + 1) begin errors++; $display("FAIL gap_second_read: got %0d expected 1", rd_count - base_rd); end
    // 0x22 is read on the edge that writes 0x23; en drops right after that edge.
    base_rd = rd_count;
    exp_q.push_back(16'h22);
    fifo_wr = 1'b1;
    fifo_wdata = 16'h22;
    step();
    fifo_wdata = 16'h23;
    step();
    fifo_wr = 1'b0;
    en = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    repeat (5) step();
    @(negedge clk);
    checks += 5;
    if (exp_q.size() != 0) begin errors++; $display("FAIL en_fall_delivery: %0d words outstanding expected 0", exp_q.size()); end
    if (rd_count != base_rd + 1) begin errors++; $display("FAIL en_fall_reads: got %0d expected 1", rd_count - base_rd); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL en_fall_fifo_left: got empty=%b expected 0", fifo_empty); end
    if (busy !== 1'b0) begin errors++; $display("FAIL en_fall_busy: got %b expected 0", busy); end
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL en_fall_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    step();
  endtask

  task automatic test_reset_mid();
    int base_rd, n;
    for (int i = 0; i < 4; i++) fifo_push(16'h40 + 16'(i));
    m_ready = 1'b0;
    en = 1'b1;
    base_rd = rd_count;
    n = 0;
    while (rd_count - base_rd < 3 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (rd_count - base_rd != 3) begin errors++; $display("FAIL rst_mid_setup: got %0d reads expected 3", rd_count - base_rd); end
    // third read is now in flight with two words buffered
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks += 5;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_mid_fifo_read: got %b expected 0", fifo_read); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid: got %b expected 0", m_valid); end
    if (m_data !== 16'h0) begin errors++; $display("FAIL rst_mid_m_data: got %h expected 0000", m_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (word_count !== 16'd0) begin errors++; $display("FAIL rst_mid_word_count: got %0d expected 0", word_count); end
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    checks += 2;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_late_capture: m_valid got %b expected 0", m_valid); end
    if (word_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count_after: got %0d expected 0", word_count); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_back_pressure();
    test_flush();
    test_gap_enable();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
